// File: rtl/mmul_sequencer.sv
// mmul_sequencer: expands one MMUL_D / MMUL_ND instruction into per-row
// fetch beats, a fixed latency wait and (MMUL_D only) per-row commit beats.
// Optional feature macro: MMUL_SEQ_PREFETCH_EN (1-entry instruction buffer so
// a queued instruction starts fetching right after the current done beat).

package common_pkg;

    localparam int unsigned T_C        = 4;
    localparam int unsigned T_D        = 8;
    localparam int unsigned ADDR_WIDTH = 10;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef enum logic {
        MMUL_ND = 1'b0,
        MMUL_D  = 1'b1
    } op_t;

    typedef struct packed {
        op_t   op;
        addr_t src1;
        addr_t src2;
        addr_t dest;
    } instruction_t;

    typedef struct packed {
        logic  valid;
        addr_t src1;
        addr_t src2;
        logic  drain;
    } fetch_t;

    typedef struct packed {
        logic  valid;
        addr_t dest;
    } commit_t;

    typedef struct packed {
        fetch_t  fetch;
        commit_t commit;
    } ctrl_signals_t;

endpackage

module mmul_sequencer
    import common_pkg::*;
#(
    parameter int unsigned T_C        = common_pkg::T_C,
    parameter int unsigned T_D        = common_pkg::T_D,
    parameter int unsigned ADDR_WIDTH = common_pkg::ADDR_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          instr_valid_i,
    output logic          instr_ready_o,
    input  instruction_t  instr_i,
    output ctrl_signals_t ctrl_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int unsigned CNT_MAX = (T_C > T_D) ? T_C : T_D;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_COMMIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    instruction_t       r_instr;
    instruction_t       w_instr_nxt;
    ctrl_signals_t      r_ctrl;
    ctrl_signals_t      w_ctrl_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic               w_accept;
    logic               w_cnt_last_c;
    logic               w_cnt_last_d;
    logic               w_last_beat;

`ifdef MMUL_SEQ_PREFETCH_EN
    logic               r_buf_valid;
    logic               w_buf_valid_nxt;
    instruction_t       r_buf_instr;
    instruction_t       w_buf_instr_nxt;

    assign instr_ready_o = (r_state == S_IDLE) || !r_buf_valid;
`else
    assign instr_ready_o = (r_state == S_IDLE);
`endif

    assign w_accept     = instr_valid_i && instr_ready_o;
    assign w_cnt_last_c = (r_cnt == CNT_W'(T_C - 1));
    assign w_cnt_last_d = (r_cnt == CNT_W'(T_D - 1));

    // The beat currently on ctrl_o is the final beat of its instruction
    assign w_last_beat  = ((r_state == S_FETCH) && w_cnt_last_c && (r_instr.op == MMUL_ND)) ||
                          ((r_state == S_COMMIT) && w_cnt_last_c);

    assign busy_o = (r_state != S_IDLE);
    assign ctrl_o = r_ctrl;
    assign done_o = r_done;

    // Next-state, counter and latched-instruction logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_instr_nxt = r_instr;
`ifdef MMUL_SEQ_PREFETCH_EN
        w_buf_valid_nxt = r_buf_valid;
        w_buf_instr_nxt = r_buf_instr;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_FETCH;
                    w_cnt_nxt   = '0;
                    w_instr_nxt = instr_i;
                end
            end
            S_FETCH: begin
                if (w_cnt_last_c) begin
                    w_state_nxt = (r_instr.op == MMUL_D) ? S_WAIT : S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (w_cnt_last_d) begin
                    w_state_nxt = S_COMMIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_COMMIT: begin
                if (w_cnt_last_c) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
`ifdef MMUL_SEQ_PREFETCH_EN
        // On the final beat, chain straight into the buffered (or just
        // offered) instruction instead of passing through IDLE.
        if (w_last_beat) begin
            if (r_buf_valid) begin
                w_state_nxt     = S_FETCH;
                w_cnt_nxt       = '0;
                w_instr_nxt     = r_buf_instr;
                w_buf_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_state_nxt     = S_FETCH;
                w_cnt_nxt       = '0;
                w_instr_nxt     = instr_i;
            end
        end else if (w_accept && (r_state != S_IDLE)) begin
            w_buf_valid_nxt = 1'b1;
            w_buf_instr_nxt = instr_i;
        end
`endif
    end

    // Beat decode from the next state so that ctrl_o/done_o are registered
    // yet still appear in the cycle the state is entered.
    always_comb begin
        w_ctrl_nxt = '0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_FETCH: begin
                w_ctrl_nxt.fetch.valid = 1'b1;
                w_ctrl_nxt.fetch.src1  = w_instr_nxt.src1 + ADDR_WIDTH'(w_cnt_nxt);
                w_ctrl_nxt.fetch.src2  = w_instr_nxt.src2 + ADDR_WIDTH'(w_cnt_nxt);
                w_ctrl_nxt.fetch.drain = (w_instr_nxt.op == MMUL_D);
                w_done_nxt = (w_cnt_nxt == CNT_W'(T_C - 1)) && (w_instr_nxt.op == MMUL_ND);
            end
            S_COMMIT: begin
                w_ctrl_nxt.commit.valid = 1'b1;
                w_ctrl_nxt.commit.dest  = w_instr_nxt.dest + ADDR_WIDTH'(w_cnt_nxt);
                w_done_nxt = (w_cnt_nxt == CNT_W'(T_C - 1));
            end
            default: begin
                w_ctrl_nxt = '0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // State, counter, instruction and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_instr <= '0;
            r_ctrl  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_instr <= w_instr_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef MMUL_SEQ_PREFETCH_EN
    // One-entry look-ahead instruction buffer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_buf_valid <= 1'b0;
            r_buf_instr <= '0;
        end else begin
            r_buf_valid <= w_buf_valid_nxt;
            r_buf_instr <= w_buf_instr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_mmul_sequencer.sv
// Self-checking bench for mmul_sequencer: expected beats are queued when an
// instruction is driven and popped as the DUT emits valid/done beats.
module tb_mmul_sequencer;
    import common_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ivalid = 1'b0;
    logic          iready;
    instruction_t  instr = '0;
    ctrl_signals_t ctrl;
    logic          busy;
    logic          done;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int            cyc;
        ctrl_signals_t ctrl;
        logic          done;
    } exp_t;
    exp_t sb[$];

    mmul_sequencer dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_valid_i (ivalid),
        .instr_ready_o (iready),
        .instr_i       (instr),
        .ctrl_o        (ctrl),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the beats an instruction accepted in cycle c0 must produce
    task automatic push_instr(input int c0, input instruction_t in);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.cyc  = c0 + 1 + k;
            e.ctrl = '0;
            e.ctrl.fetch.valid = 1'b1;
            e.ctrl.fetch.src1  = in.src1 + addr_t'(k);
            e.ctrl.fetch.src2  = in.src2 + addr_t'(k);
            e.ctrl.fetch.drain = (in.op == MMUL_D);
            e.done = (in.op == MMUL_ND) && (k == 3);
            sb.push_back(e);
        end
        if (in.op == MMUL_D) begin
            for (int k = 0; k < 4; k++) begin
                e.cyc  = c0 + 13 + k;
                e.ctrl = '0;
                e.ctrl.commit.valid = 1'b1;
                e.ctrl.commit.dest  = in.dest + addr_t'(k);
                e.done = (k == 3);
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor: every cycle carrying a valid or done must match the next expected beat
    always @(negedge clk) begin
        exp_t e;
        if (ctrl.fetch.valid !== 1'b0 || ctrl.commit.valid !== 1'b0 || done !== 1'b0) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_beat: got ctrl %h done %b at cycle %0d expected no beat", ctrl, done, cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("beat_cycle", 64'(cyc), 64'(e.cyc));
                chk("beat_ctrl", 64'(ctrl), 64'(e.ctrl));
                chk("beat_done", 64'(done), 64'(e.done));
            end
        end
    end

    initial begin
        instruction_t a, b, c;
        int c0;
        logic exp_rdy;
        int acc_k;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(iready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ctrl", 64'(ctrl), 64'd0);

        // MMUL_D with a second instruction held on the bus behind it
        tick();
        a = '{op: MMUL_D, src1: 10'h010, src2: 10'h020, dest: 10'h030};
        b = '{op: MMUL_D, src1: 10'h040, src2: 10'h050, dest: 10'h060};
        c0 = cyc;
        instr  = a;
        ivalid = 1'b1;
        push_instr(c0, a);
`ifdef MMUL_SEQ_PREFETCH_EN
        push_instr(c0 + 16, b);
        acc_k = 1;
`else
        push_instr(c0 + 17, b);
        acc_k = 17;
`endif
        tick();
        instr = b;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
`ifdef MMUL_SEQ_PREFETCH_EN
            exp_rdy = (k == 1) || (k == 17);
`else
            exp_rdy = (k == 17);
`endif
            chk("b2b_ready", 64'(iready), 64'(exp_rdy));
            if (k <= 16) chk("b2b_busy", 64'(busy), 64'd1);
            tick();
            if (k == acc_k) ivalid = 1'b0;
        end
        instr = '0;
        wait_drain("drain_b2b");
        chk("idle_ready_b2b", 64'(iready), 64'd1);
        chk("idle_busy_b2b", 64'(busy), 64'd0);

        // MMUL_ND: fetch only, done on 4th beat, idle right after
        tick();
        a = '{op: MMUL_ND, src1: 10'h100, src2: 10'h200, dest: 10'h0AA};
        c0 = cyc;
        instr  = a;
        ivalid = 1'b1;
        push_instr(c0, a);
        tick();
        ivalid = 1'b0;
        instr  = '0;
        wait_drain("drain_nd");
        chk("nd_idle_ready", 64'(iready), 64'd1);
        chk("nd_idle_busy", 64'(busy), 64'd0);

        // Address wrap at the top of the 10-bit row space
        tick();
        a = '{op: MMUL_D, src1: 10'h3FE, src2: 10'h3FF, dest: 10'h3FD};
        c0 = cyc;
        instr  = a;
        ivalid = 1'b1;
        push_instr(c0, a);
        tick();
        ivalid = 1'b0;
        instr  = '0;
        wait_drain("drain_wrap");

        // Asynchronous reset during the 2nd commit beat
        tick();
        c = '{op: MMUL_D, src1: 10'h001, src2: 10'h002, dest: 10'h200};
        c0 = cyc;
        instr  = c;
        ivalid = 1'b1;
        push_instr(c0, c);
        tick();
        ivalid = 1'b0;
        instr  = '0;
        repeat (13) tick();
        chk("pre_rst_commit", 64'(ctrl.commit.valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", 64'(ctrl), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        chk("async_rst_pending", 64'(sb.size()), 64'd3);
        sb.delete();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(iready), 64'd1);
        repeat (20) tick();
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Short MMUL_D after reset to show the sequencer is usable again
        a = '{op: MMUL_D, src1: 10'h0F0, src2: 10'h0E0, dest: 10'h0D0};
        c0 = cyc;
        instr  = a;
        ivalid = 1'b1;
        push_instr(c0, a);
        tick();
        ivalid = 1'b0;
        instr  = '0;
        wait_drain("drain_post_rst");

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
